// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (7-bit addressing, one write or one
// read byte per transaction, no clock stretching, no repeated start).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    one-cycle transaction request, honoured only while busy=0
//   addr     7-bit slave address, captured on accepted start
//   rw       1=read, 0=write, captured on accepted start
//   wdata    write byte, captured on accepted start
//   busy     high from the cycle after start is accepted until STOP completes
//   done     one-cycle pulse when STOP completes
//   ack_err  address or write byte NACKed; valid with done
//   rdata    received byte, updated only at the end of a successful read
//   scl      I2C clock, push-pull
//   sda      I2C data, open-drain (drives 0 or Z)
//
// Each bit slot is four quarter periods of CLK_DIV clocks:
//   Q0 SCL low, SDA updated one clk into the quarter
//   Q1 SCL high
//   Q2 SDA sampled at the end of the quarter
//   Q3 SCL low
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  inout  wire logic  sda
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] qtr_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       rw_q;
  logic       scl_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;

  logic       tick;
  logic       q0_first;
  logic       bit_low;
  logic       sda_in;

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in  = sda;

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl     = scl_q;

  // Quarter-period prescaler; idles at zero so every transaction starts aligned.
  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (state_q != S_IDLE) begin
      if (cnt_q == DIV_LAST) tick = 1'b1;
      else                   cnt_d = cnt_q + 8'd1;
    end
  end

  // SDA moves one clk after Q0 begins, so it never shares an edge with the
  // SCL fall that ends START.
  assign q0_first = (qtr_q == 2'd0) && (cnt_q == '0);

  always_comb begin
    bit_low = 1'b0;
    if (state_q == S_ADDR || state_q == S_WRITE) bit_low = ~shift_q[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          qtr_q    <= '0;
          bit_q    <= '0;
          // busy_q is still 1 in the done cycle, which blocks a same-cycle start.
          if (start && !busy_q) begin
            shift_q   <= {addr, rw};
            rw_q      <= rw;
            wdata_q   <= wdata;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b1;
            sda_oe_q  <= 1'b1;
            state_q   <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            if (qtr_q == 2'd1) begin
              scl_q   <= 1'b0;
              qtr_q   <= '0;
              bit_q   <= '0;
              state_q <= S_ADDR;
            end else begin
              qtr_q <= qtr_q + 2'd1;
            end
          end
        end

        S_STOP: begin
          if (q0_first) sda_oe_q <= 1'b1;
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd0:    scl_q    <= 1'b1;
              2'd1:    sda_oe_q <= 1'b0;
              default: begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            endcase
          end
        end

        default: begin
          if (q0_first) sda_oe_q <= bit_low;
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd0: scl_q <= 1'b1;
              2'd2: begin
                scl_q <= 1'b0;
                case (state_q)
                  S_ADDR_ACK, S_WRITE_ACK: if (sda_in) ack_err_q <= 1'b1;
                  S_READ:                  shift_q <= {shift_q[6:0], sda_in};
                  default: ;
                endcase
              end
              2'd3: begin
                case (state_q)
                  S_ADDR, S_WRITE: begin
                    shift_q <= {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                      bit_q   <= '0;
                      state_q <= (state_q == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                    end else begin
                      bit_q <= bit_q + 3'd1;
                    end
                  end
                  S_ADDR_ACK: begin
                    // ack_err_q was cleared at start, so here it reflects only the address NACK.
                    if (ack_err_q) begin
                      state_q <= S_STOP;
                    end else if (rw_q) begin
                      state_q <= S_READ;
                    end else begin
                      shift_q <= wdata_q;
                      state_q <= S_WRITE;
                    end
                  end
                  S_READ: begin
                    if (bit_q == 3'd7) begin
                      bit_q   <= '0;
                      state_q <= S_READ_ACK;
                    end else begin
                      bit_q <= bit_q + 3'd1;
                    end
                  end
                  S_READ_ACK: begin
                    rdata_q <= shift_q;
                    state_q <= S_STOP;
                  end
                  default: state_q <= S_STOP;
                endcase
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a clocked bus monitor
// acting as a single-register slave at address 7'h77.
module tb_i2c_master;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl;
  wire        sda;

  pullup (sda);

  logic       s_low = 1'b0;
  assign sda = s_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata),
    .scl     (scl),
    .sda     (sda)
  );

  always #5 clk = ~clk;

  // ---------------- bus monitor / slave model ----------------
  typedef enum logic [2:0] {M_IDLE, M_ADDR, M_AACK, M_WR, M_WACK, M_RD, M_RACK, M_END} mstate_t;

  mstate_t     m_st = M_IDLE;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_frame = 1'b0;
  logic        s_sel = 1'b0, s_rw = 1'b0;
  logic [7:0]  s_sh = '0, s_mem = '0, s_addr_byte = '0;
  logic        stop_seen = 1'b0, rack_val = 1'b0;
  int unsigned s_cnt = 0, rises = 0, done_cnt = 0, glitches = 0;
  int unsigned period = 0, cyc = 0, last_rise = 0;
  logic        slave_rst = 1'b0;
  logic [7:0]  mem_init = 8'hAA;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl;
    prev_sda <= sda;
    if (slave_rst) s_mem <= mem_init;
    if (done) done_cnt <= done_cnt + 1;
    if (rst) begin
      in_frame <= 1'b0;
      m_st     <= M_IDLE;
      s_low    <= 1'b0;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      // START (SDA falls with SCL high); inside a frame it is an illegal SDA change
      if (in_frame) glitches <= glitches + 1;
      in_frame  <= 1'b1;
      m_st      <= M_ADDR;
      s_cnt     <= 0;
      rises     <= 0;
      done_cnt  <= 0;
      stop_seen <= 1'b0;
      period    <= 0;
      rack_val  <= 1'b0;
      s_low     <= 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      if (in_frame) begin
        stop_seen <= 1'b1;
        in_frame  <= 1'b0;
        m_st      <= M_IDLE;
      end
    end else if (!prev_scl && scl) begin
      if (in_frame) begin
        rises     <= rises + 1;
        if (rises == 1) period <= cyc - last_rise;
        last_rise <= cyc;
        case (m_st)
          M_ADDR, M_WR: begin
            s_sh  <= {s_sh[6:0], sda};
            s_cnt <= s_cnt + 1;
          end
          M_RD:    s_cnt    <= s_cnt + 1;
          M_RACK:  rack_val <= sda;
          default: ;
        endcase
      end
    end else if (prev_scl && !scl) begin
      // SCL activity outside a frame means a data change was mistaken for STOP
      if (!in_frame) glitches <= glitches + 1;
      else begin
        case (m_st)
          M_ADDR: if (s_cnt == 8) begin
            s_addr_byte <= s_sh;
            s_sel       <= (s_sh[7:1] == 7'h77);
            s_rw        <= s_sh[0];
            s_low       <= (s_sh[7:1] == 7'h77);
            m_st        <= M_AACK;
          end
          M_AACK: begin
            if (!s_sel) begin
              s_low <= 1'b0;
              m_st  <= M_END;
            end else if (s_rw) begin
              m_st  <= M_RD;
              s_cnt <= 0;
              s_low <= !s_mem[7];
            end else begin
              m_st  <= M_WR;
              s_cnt <= 0;
              s_low <= 1'b0;
            end
          end
          M_WR: if (s_cnt == 8) begin
            s_mem <= s_sh;
            s_low <= 1'b1;
            m_st  <= M_WACK;
          end
          M_WACK: begin
            s_low <= 1'b0;
            m_st  <= M_END;
          end
          M_RD: begin
            if (s_cnt == 8) begin
              s_low <= 1'b0;
              m_st  <= M_RACK;
            end else begin
              s_low <= !s_mem[3'(7 - s_cnt)];
            end
          end
          M_RACK:  m_st <= M_END;
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [7:0] m);
    @(negedge clk); #1 mem_init = m; slave_rst = 1'b1;
    @(negedge clk); #1 slave_rst = 1'b0;
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w,
                        output logic bsy_next);
    @(negedge clk);
    addr = a; rw = r; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bsy_next = busy;
  endtask

  task automatic wait_done(output logic got, output logic err, output logic [7:0] rd,
                           output logic bsy);
    got = 1'b0; err = 1'b0; rd = '0; bsy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; err = ack_err; rd = rdata; bsy = busy;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  mem_init;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_mem;
    int unsigned exp_rises;
  } vec_t;

  vec_t        vecs [6];
  logic        got, err, bsy, bsy_next, ok;
  logic [7:0]  rd;
  int unsigned activity;

  initial begin
    // addr, rw, wdata, slave mem, ack_err, rdata, slave mem after, SCL rises incl. STOP
    vecs[0] = '{7'h77, 1'b1, 8'h00, 8'hAA, 1'b0, 8'hAA, 8'hAA, 19};
    vecs[1] = '{7'h77, 1'b0, 8'h5A, 8'hAA, 1'b0, 8'hAA, 8'h5A, 19};
    vecs[2] = '{7'h10, 1'b0, 8'h33, 8'h5A, 1'b1, 8'hAA, 8'h5A, 10};
    vecs[3] = '{7'h77, 1'b1, 8'h00, 8'hC3, 1'b0, 8'hC3, 8'hC3, 19};
    vecs[4] = '{7'h10, 1'b1, 8'h00, 8'hC3, 1'b1, 8'hC3, 8'hC3, 10};
    vecs[5] = '{7'h77, 1'b0, 8'h81, 8'hC3, 1'b0, 8'hC3, 8'h81, 19};

    rst = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_scl",   32'(scl),     32'd1);
    check("rst_sda",   32'(sda),     32'd1);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_err",   32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata),   32'h00);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load_mem(vecs[i].mem_init);
      launch(vecs[i].addr, vecs[i].rw, vecs[i].wdata, bsy_next);
      wait_done(got, err, rd, bsy);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_busy_after_start", i), 32'(bsy_next), 32'd1);
      check($sformatf("v%0d_done_seen", i),   32'(got),   32'd1);
      check($sformatf("v%0d_busy_at_done", i), 32'(bsy),  32'd1);
      check($sformatf("v%0d_ack_err", i),     32'(err),   32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i),       32'(rd),    32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_slave_mem", i),   32'(s_mem), 32'(vecs[i].exp_mem));
      check($sformatf("v%0d_addr_byte", i),   32'(s_addr_byte), 32'({vecs[i].addr, vecs[i].rw}));
      check($sformatf("v%0d_scl_rises", i),   rises,      vecs[i].exp_rises);
      check($sformatf("v%0d_scl_period", i),  period,     32'(4 * CLK_DIV));
      check($sformatf("v%0d_stop", i),        32'(stop_seen), 32'd1);
      check($sformatf("v%0d_done_pulses", i), done_cnt,   32'd1);
      check($sformatf("v%0d_busy_end", i),    32'(busy),  32'd0);
      check($sformatf("v%0d_sda_stable", i),  glitches,   32'd0);
      if (vecs[i].rw && !vecs[i].exp_err)
        check($sformatf("v%0d_master_nack", i), 32'(rack_val), 32'd1);
    end

    // start pulsed mid-transfer with different fields is ignored
    load_mem(8'hAA);
    launch(7'h77, 1'b0, 8'h5A, bsy_next);
    repeat (40) @(negedge clk);
    addr = 7'h01; rw = 1'b1; wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got, err, rd, bsy);
    repeat (3) @(negedge clk);
    check("ign_done",      32'(got),         32'd1);
    check("ign_ack_err",   32'(err),         32'd0);
    check("ign_addr_byte", 32'(s_addr_byte), 32'hEE);
    check("ign_slave_mem", 32'(s_mem),       32'h5A);
    check("ign_rises",     rises,            32'd19);
    check("ign_pulses",    done_cnt,         32'd1);

    // start held in the same cycle as done is ignored
    load_mem(8'h00);
    launch(7'h77, 1'b0, 8'h3C, bsy_next);
    wait_done(got, err, rd, bsy);
    addr = 7'h01; rw = 1'b1; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    activity = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || !scl) activity++;
    end
    check("dcyc_done",      32'(got),   32'd1);
    check("dcyc_mem",       32'(s_mem), 32'h3C);
    check("dcyc_no_restart", activity,  32'd0);

    // asynchronous reset partway through the address byte
    load_mem(8'h00);
    launch(7'h77, 1'b0, 8'h5A, bsy_next);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (m_st == M_ADDR && s_cnt == 3 && !scl) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_bit3", 32'(ok),   32'd1);
    check("rst_pre_scl",    32'(scl),  32'd0);
    check("rst_pre_busy",   32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_scl",   32'(scl),     32'd1);
    check("arst_sda",   32'(sda),     32'd1);
    check("arst_busy",  32'(busy),    32'd0);
    check("arst_done",  32'(done),    32'd0);
    check("arst_err",   32'(ack_err), 32'd0);
    check("arst_rdata", 32'(rdata),   32'h00);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("arst_mem_untouched", 32'(s_mem), 32'h00);

    launch(7'h77, 1'b0, 8'hA5, bsy_next);
    wait_done(got, err, rd, bsy);
    repeat (3) @(negedge clk);
    check("post_rst_done",   32'(got),   32'd1);
    check("post_rst_err",    32'(err),   32'd0);
    check("post_rst_rdata",  32'(rd),    32'h00);
    check("post_rst_mem",    32'(s_mem), 32'hA5);
    check("post_rst_rises",  rises,      32'd19);
    check("post_rst_stop",   32'(stop_seen), 32'd1);
    check("post_rst_stable", glitches,   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
